vend_seq_ctrl: RTL
==================

Name: vend_seq_ctrl

Overview:
- Sequencing controller for the coin-operated vending datapath.
- Accumulates credit from one/two/five-unit coin pulses and requests a product dispense once credit reaches PRICE.
- Pays out change one unit at a time through a coin-return mechanism, using a req/ack handshake for each unit.
- Handles cancel and inactivity-timeout refunds. Sits between the coin acceptor inputs and the dispenser and coin-return actuators.

Parameters:
- PRICE, 5, product price in units (1..15).
- CREDIT_W, 4, credit register width. Must hold PRICE-1+5.
- TIMEOUT_CYC, 1000, idle cycles with nonzero credit before auto-refund (>=2).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- one  in  1  one-unit coin pulse, single cycle
- two  in  1  two-unit coin pulse, single cycle
- five  in  1  five-unit coin pulse, single cycle
- cancel  in  1  refund request, level, sampled each cycle
- disp_ack  in  1  dispenser acknowledge
- change_ack  in  1  coin-return acknowledge, one unit paid per ack
- disp_req  out  1  dispense request
- change_req  out  1  return-one-unit request
- coin_reject  out  1  registered one-cycle pulse: coin not accepted
- vend_done  out  1  registered one-cycle pulse at end of a complete vend including change
- busy  out  1  high in any state except COLLECT
- credit  out  CREDIT_W  current credit
- state  out  2  current state encoding, debug

Behaviour:
Reset:
- reset_n low: state=COLLECT, credit=0, timeout counter=0, all outputs 0. Takes effect immediately (asynchronous).
- Reset mid-handshake drops disp_req/change_req at once. Credit is lost.

States (2-bit encoding): COLLECT=00, DISPENSE=01, CHANGE=10, REFUND=11. All outputs are registered.

COLLECT:
- Exactly one coin bit high at edge N: credit += value, visible after edge N.
- Two or more coin bits high together: no credit change, coin_reject=1 for the cycle after edge N.
- cancel has priority over a coin in the same cycle. The coin is rejected. If credit>0, go to REFUND; if credit==0, stay.
- After an accepted coin, if the new credit >= PRICE, go to DISPENSE at edge N+1 and disp_req=1 from N+1. Coin-to-disp_req latency is 2 edges.
- Timeout counter clears on any coin and whenever credit==0. Otherwise it increments each cycle. On reaching TIMEOUT_CYC-1, go to REFUND.

DISPENSE:
- Hold disp_req until disp_ack is sampled high. At that edge: disp_req=0, credit -= PRICE.
- Then go to CHANGE if the remainder is >0. Otherwise go to COLLECT with vend_done=1.
- cancel is ignored once in DISPENSE.

CHANGE and REFUND (common payout engine):
- change_req held high while credit>0.
- Each edge with change_req&&change_ack: credit -= 1. When credit reaches 0, change_req drops on that same edge.
- change_ack with credit==0 is ignored and never underflows.
- CHANGE exits to COLLECT with vend_done=1. REFUND exits to COLLECT with no vend_done.

Busy states:
- Any coin during DISPENSE/CHANGE/REFUND produces coin_reject with no credit change.
- busy=1 in these states.

Invariants:
- credit never exceeds PRICE+4 and never wraps.
- disp_req and change_req are never high together.

Decomposition:
- Package vend_pkg: state encoding constants, coin values (1,2,5), default PRICE.
- Sub-module vend_payout: credit down-counter plus change_req/change_ack handshake. It is shared by CHANGE and REFUND and has a load/start/done interface.
- The top level holds the state machine and timeout counter.

Test Plan:
- Coins 2,2,1 with PRICE=5 -> credit 2,4,5. disp_req rises 2 edges after the third coin. After disp_ack: credit=0, vend_done pulses, change_req never asserts.
- Coins 2,5 -> credit 7, DISPENSE. After disp_ack: credit=2, CHANGE. Two change_ack handshakes -> credit=0, vend_done=1, back to COLLECT.
- Coin 2, then cancel -> REFUND, two change_req/ack handshakes, credit 0. vend_done stays 0, disp_req never asserts.
- one and five high in the same cycle -> coin_reject pulse, credit unchanged. A coin while disp_req is pending -> coin_reject, credit unchanged.
- Coin 1, then no activity for TIMEOUT_CYC cycles (use 8) -> REFUND entered, one unit returned, COLLECT with credit 0.
- Drive reset_n low while change_req=1 and credit=3 -> change_req, credit and state go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg: shared constants and helpers for the vending sequencing controller.
//   - State encoding used by vend_seq_ctrl (also exported on the debug port).
//   - Coin denominations and the default product price.
//   - coin_value(): maps a coin pulse to its unit value.
// ----------------------------------------------------------------------------
package vend_pkg;

  localparam logic [1:0] ST_COLLECT  = 2'b00;
  localparam logic [1:0] ST_DISPENSE = 2'b01;
  localparam logic [1:0] ST_CHANGE   = 2'b10;
  localparam logic [1:0] ST_REFUND   = 2'b11;

  localparam logic [2:0] COIN_ONE_VAL  = 3'd1;
  localparam logic [2:0] COIN_TWO_VAL  = 3'd2;
  localparam logic [2:0] COIN_FIVE_VAL = 3'd5;

  localparam int DEFAULT_PRICE = 5;

  // Value of the coin pulse; only meaningful when exactly one bit is high.
  function automatic logic [2:0] coin_value(input logic one, input logic two,
                                            input logic five);
    logic [2:0] val;
    if (one) begin
      val = COIN_ONE_VAL;
    end else if (two) begin
      val = COIN_TWO_VAL;
    end else if (five) begin
      val = COIN_FIVE_VAL;
    end else begin
      val = 3'd0;
    end
    return val;
  endfunction

endpackage

// File: rtl/vend_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// vend_seq_ctrl_if: bundle between the vending controller and its environment.
//   Inputs to controller : one, two, five, cancel, disp_ack, change_ack
//   Outputs of controller: disp_req, change_req, coin_reject, vend_done, busy,
//                          credit[CREDIT_W-1:0], state[1:0]
//   modport master: the controller side (drives the actuator requests).
//   modport slave : coin acceptor / dispenser / coin-return side.
// ----------------------------------------------------------------------------
interface vend_seq_ctrl_if #(parameter int CREDIT_W = 4);
  import vend_pkg::*;

  logic                one;
  logic                two;
  logic                five;
  logic                cancel;
  logic                disp_ack;
  logic                change_ack;
  logic                disp_req;
  logic                change_req;
  logic                coin_reject;
  logic                vend_done;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          state;

  modport master (
    input  one, two, five, cancel, disp_ack, change_ack,
    output disp_req, change_req, coin_reject, vend_done, busy, credit, state
  );

  modport slave (
    output one, two, five, cancel, disp_ack, change_ack,
    input  disp_req, change_req, coin_reject, vend_done, busy, credit, state
  );

endinterface

// File: rtl/vend_payout.sv
// ----------------------------------------------------------------------------
// vend_payout: credit register plus the one-unit-per-ack payout handshake.
//   clk, reset_n   : clock, asynchronous active-low reset
//   load, load_val : overwrite the credit register
//   start          : raise change_req (caller guarantees credit > 0)
//   change_ack     : one unit paid per ack while change_req is high
//   credit         : registered credit
//   change_req     : registered return-one-unit request
//   done           : the unit paid on the coming edge is the last one
// ----------------------------------------------------------------------------
module vend_payout
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                start,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_req,
  output logic                done
);

  localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = {{(CREDIT_W-1){1'b0}}, 1'b1};

  logic [CREDIT_W-1:0] credit_r;
  logic                change_req_r;
  logic                pay_s;
  logic                last_s;

  // Payment strobe; the zero guard keeps a stray ack from underflowing.
  always_comb begin
    pay_s  = change_req_r && change_ack && (credit_r != CREDIT_ZERO);
    last_s = pay_s && (credit_r == CREDIT_ONE);
  end

  // Credit register and request flag; request drops on the edge paying the last unit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_r     <= CREDIT_ZERO;
      change_req_r <= 1'b0;
    end else begin
      if (load) begin
        credit_r <= load_val;
      end else if (pay_s) begin
        credit_r <= credit_r - CREDIT_ONE;
      end else begin
        credit_r <= credit_r;
      end
      if (start) begin
        change_req_r <= 1'b1;
      end else if (last_s) begin
        change_req_r <= 1'b0;
      end else begin
        change_req_r <= change_req_r;
      end
    end
  end

  assign credit     = credit_r;
  assign change_req = change_req_r;
  assign done       = last_s;

endmodule

// File: rtl/vend_seq_ctrl.sv
// ----------------------------------------------------------------------------
// vend_seq_ctrl: vending sequencing controller (top).
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : vend_seq_ctrl_if.master (coins, cancel, acks in; requests,
//             pulses, busy, credit, state out). All outputs are registered.
// Holds the COLLECT/DISPENSE/CHANGE/REFUND state machine and the inactivity
// timer; credit and the payout handshake live in vend_payout.
// ----------------------------------------------------------------------------
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = DEFAULT_PRICE,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vend_seq_ctrl_if.master        bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]    TMO_ZERO    = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]    TMO_ONE     = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C     = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};

  logic [1:0]          state_r, state_n;
  logic [TMO_W-1:0]    tmo_r, tmo_n;
  logic                disp_req_r, disp_req_n;
  logic                coin_reject_r, reject_n;
  logic                vend_done_r, done_n;
  logic                busy_r;
  logic                load_s, start_s, pay_done_s, change_req_s;
  logic [CREDIT_W-1:0] load_val_s, credit_s, coin_sum_s, remainder_s;
  logic                coin_any_s, coin_single_s;

  vend_payout #(.CREDIT_W(CREDIT_W)) u_payout (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_s),
    .load_val   (load_val_s),
    .start      (start_s),
    .change_ack (bus.change_ack),
    .credit     (credit_s),
    .change_req (change_req_s),
    .done       (pay_done_s)
  );

  // Coin decode and candidate credit values.
  always_comb begin
    coin_any_s    = bus.one | bus.two | bus.five;
    coin_single_s = $onehot({bus.one, bus.two, bus.five});
    coin_sum_s    = credit_s + CREDIT_W'(coin_value(bus.one, bus.two, bus.five));
    remainder_s   = credit_s - PRICE_C;
  end

  // Next-state, timer and output-pulse logic.
  always_comb begin
    state_n    = state_r;
    tmo_n      = TMO_ZERO;
    disp_req_n = 1'b0;
    reject_n   = coin_any_s;     // any coin not explicitly accepted is rejected
    done_n     = 1'b0;
    load_s     = 1'b0;
    load_val_s = credit_s;
    start_s    = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        if (credit_s >= PRICE_C) begin
          // Price reached on the previous edge: commit to the vend.
          state_n    = ST_DISPENSE;
          disp_req_n = 1'b1;
        end else if (bus.cancel) begin
          if (credit_s != CREDIT_ZERO) begin
            state_n = ST_REFUND;
            start_s = 1'b1;
          end else begin
            state_n = ST_COLLECT;
          end
        end else if (coin_single_s) begin
          // Credit is below PRICE here, so the sum stays within PRICE+4.
          reject_n   = 1'b0;
          load_s     = 1'b1;
          load_val_s = coin_sum_s;
        end else if (coin_any_s) begin
          tmo_n = TMO_ZERO;
        end else if (credit_s == CREDIT_ZERO) begin
          tmo_n = TMO_ZERO;
        end else if (tmo_r == TMO_LAST) begin
          state_n = ST_REFUND;
          start_s = 1'b1;
        end else begin
          tmo_n = tmo_r + TMO_ONE;
        end
      end
      ST_DISPENSE: begin
        if (bus.disp_ack) begin
          load_s     = 1'b1;
          load_val_s = remainder_s;
          if (remainder_s != CREDIT_ZERO) begin
            state_n = ST_CHANGE;
            start_s = 1'b1;
          end else begin
            state_n = ST_COLLECT;
            done_n  = 1'b1;
          end
        end else begin
          disp_req_n = 1'b1;
        end
      end
      ST_CHANGE, ST_REFUND: begin
        if (pay_done_s) begin
          state_n = ST_COLLECT;
          done_n  = (state_r == ST_CHANGE);
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = ST_COLLECT;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_COLLECT;
      tmo_r         <= TMO_ZERO;
      disp_req_r    <= 1'b0;
      coin_reject_r <= 1'b0;
      vend_done_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      tmo_r         <= tmo_n;
      disp_req_r    <= disp_req_n;
      coin_reject_r <= reject_n;
      vend_done_r   <= done_n;
      busy_r        <= (state_n != ST_COLLECT);
    end
  end

  assign bus.disp_req    = disp_req_r;
  assign bus.change_req  = change_req_s;
  assign bus.coin_reject = coin_reject_r;
  assign bus.vend_done   = vend_done_r;
  assign bus.busy        = busy_r;
  assign bus.credit      = credit_s;
  assign bus.state       = state_r;

endmodule
